// File: rtl/mult_div_if.sv
// Multiply/divide unit bus.
// The execute stage (master) drives the operation request, the E-stage
// stall, the exception flush and the MTHI/MTLO write; the unit (slave)
// returns the busy flag, the HI/LO registers and its FSM state for debug.
//
// Handshake: a request is taken on a rising clk edge where startE=1,
// stallE=0, abort=0 and the unit is idle (mdrunE=0). While mdrunE=1 the
// unit ignores startE and the MTHI/MTLO strobes; the requester must keep
// HI/LO readers stalled until mdrunE returns to 0.
//
// Signals:
//   startE, mdopE[1:0], srcaE, srcbE : operation request and operands
//   stallE, abort                    : E-stage hold, exception flush
//   hiwriteE, lowriteE, hiwdataE     : MTHI / MTLO
//   mdrunE                           : operation in progress
//   hi, lo                           : architectural HI/LO registers
//   mdState                          : FSM state (0=IDLE 1=RUN 2=FIX)
interface mult_div_if #(parameter int WIDTH = 32);
  logic             startE;
  logic [1:0]       mdopE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             stallE;
  logic             abort;
  logic             hiwriteE;
  logic             lowriteE;
  logic [WIDTH-1:0] hiwdataE;
  logic             mdrunE;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       mdState;

  modport master (
    output startE, mdopE, srcaE, srcbE, stallE, abort,
           hiwriteE, lowriteE, hiwdataE,
    input  mdrunE, hi, lo, mdState
  );

  modport slave (
    input  startE, mdopE, srcaE, srcbE, stallE, abort,
           hiwriteE, lowriteE, hiwdataE,
    output mdrunE, hi, lo, mdState
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use LSB-first shift-add, DIV/DIVU use MSB-first restoring
// division; both take WIDTH RUN cycles plus one FIX cycle for the sign
// correction and the HI/LO write.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; overrides abort and start
//   md    : mult_div_if slave (request, stall, flush, MTHI/MTLO,
//           mdrunE busy flag, hi/lo, debug state)
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave md
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               isDiv;
  logic               negq;
  logic               negr;
  logic               divZero;
  logic [WIDTH-1:0]   rawA;     // unmodified dividend, returned on divide by zero
  logic [WIDTH-1:0]   opA;      // multiplicand / dividend-then-quotient shifter
  logic [WIDTH-1:0]   opB;      // multiplier shifter / divisor
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;

  logic               isSigned;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic               accept;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

  always_comb begin
    isSigned = ~md.mdopE[0];
    sa       = isSigned & md.srcaE[WIDTH-1];
    sb       = isSigned & md.srcbE[WIDTH-1];
    absA     = sa ? -md.srcaE : md.srcaE;
    absB     = sb ? -md.srcbE : md.srcbE;
    accept   = (state == IDLE) & md.startE & ~md.stallE & ~md.abort;

    // Multiply step: add the multiplicand into the upper half when the
    // current multiplier bit is set; the carry becomes the new top bit
    // after the right shift.
    mulSum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (opB[0] ? opA : '0)};

    // Restoring divide step: bring down the next dividend bit, try the
    // subtraction and keep it only if it did not go negative.
    divShift = {rem[WIDTH-1:0], opA[WIDTH-1]};
    divDiff  = divShift - {1'b0, opB};

    prodFix  = negq ? -prod : prod;
    quoFix   = negq ? -opA : opA;
    remFix   = negr ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      isDiv   <= 1'b0;
      negq    <= 1'b0;
      negr    <= 1'b0;
      divZero <= 1'b0;
      rawA    <= '0;
      opA     <= '0;
      opB     <= '0;
      prod    <= '0;
      rem     <= '0;
      hiReg   <= '0;
      loReg   <= '0;
    end else if (md.abort) begin
      // Flush: drop the partial result, HI/LO untouched.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            isDiv   <= md.mdopE[1];
            negq    <= sa ^ sb;
            negr    <= sa;
            divZero <= md.mdopE[1] & (md.srcbE == '0);
            rawA    <= md.srcaE;
            opA     <= absA;
            opB     <= absB;
            prod    <= '0;
            rem     <= '0;
            count   <= CW'(WIDTH);
            state   <= RUN;
          end else begin
            if (md.hiwriteE) hiReg <= md.hiwdataE;
            if (md.lowriteE) loReg <= md.hiwdataE;
          end
        end
        RUN: begin
          count <= count - 1'b1;
          if (isDiv) begin
            if (!divDiff[WIDTH]) begin
              rem <= divDiff;
              opA <= {opA[WIDTH-2:0], 1'b1};
            end else begin
              rem <= divShift;
              opA <= {opA[WIDTH-2:0], 1'b0};
            end
          end else begin
            prod <= {mulSum, prod[WIDTH-1:1]};
            opB  <= {1'b0, opB[WIDTH-1:1]};
          end
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (!isDiv) begin
            hiReg <= prodFix[2*WIDTH-1:WIDTH];
            loReg <= prodFix[WIDTH-1:0];
          end else if (divZero) begin
            hiReg <= rawA;
            loReg <= '1;
          end else begin
            hiReg <= remFix;
            loReg <= quoFix;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.mdrunE  = (state == RUN) || (state == FIX);
  assign md.hi      = hiReg;
  assign md.lo      = loReg;
  assign md.mdState = state;
endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [63:0] exp_q[$];

  mult_div_if #(.WIDTH(32)) bus();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Returns {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, q, r, p;
    longint unsigned pu;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb; res = p; end
      2'b01: begin pu = {32'b0, a} * {32'b0, b}; res = pu; end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {a % b, a / b};
        end
      end
    endcase
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.startE   = 1'b0;
    bus.mdopE    = 2'b00;
    bus.srcaE    = '0;
    bus.srcbE    = '0;
    bus.stallE   = 1'b0;
    bus.abort    = 1'b0;
    bus.hiwriteE = 1'b0;
    bus.lowriteE = 1'b0;
    bus.hiwdataE = '0;
  endtask

  // Called at a negedge with the unit idle; returns at the negedge of the
  // first cycle where mdrunE is low again.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    int busy;
    logic [63:0] expv;
    exp_q.push_back(model(op, a, b));
    bus.startE = 1'b1;
    bus.mdopE  = op;
    bus.srcaE  = a;
    bus.srcbE  = b;
    @(posedge clk);
    @(negedge clk);
    bus.startE = 1'b0;
    busy = 0;
    while (bus.mdrunE === 1'b1 && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 33) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want 33", name, busy);
    end
    expv = exp_q.pop_front();
    checks++;
    if ({bus.hi, bus.lo} !== expv) begin
      errors++;
      $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, bus.hi, bus.lo,
               expv[63:32], expv[31:0]);
    end
  endtask

  task automatic mt_write(input logic hiw, input logic low, input logic [31:0] d);
    bus.hiwriteE = hiw;
    bus.lowriteE = low;
    bus.hiwdataE = d;
    @(posedge clk);
    @(negedge clk);
    bus.hiwriteE = 1'b0;
    bus.lowriteE = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.startE = 1'b1;
    bus.mdopE  = 2'b01;
    bus.srcaE  = 32'h1234_5678;
    bus.srcbE  = 32'h9;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) begin
        reset = 1'b0;
        bus.startE = 1'b0;
      end
      checks++;
      if (bus.mdrunE !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got mdrunE=%b hi=%h lo=%h want 0 0 0", i,
                 bus.mdrunE, bus.hi, bus.lo);
      end
    end
  endtask

  task automatic test_directed();
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_signed");
    checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_signed_const: got hi=%h lo=%h want ffffffff ffffffeb", bus.hi, bus.lo);
    end
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_signed");
    checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_signed_const: got hi=%h lo=%h want ffffffff fffffffd", bus.hi, bus.lo);
    end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_overflow_const: got hi=%h lo=%h want 00000000 80000000", bus.hi, bus.lo);
    end
    run_op(2'b11, 32'd5, 32'd0, "divu_zero");
    run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_0010, "divu_shift");
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, "div_pos_by_neg");
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (op == 2'b10 && b == 32'd0) b = 32'd3;
      if ($urandom_range(0, 4) == 0) a = 32'($urandom_range(0, 255));
      run_op(op, a, b, $sformatf("random_%0d_op%0d", i, op));
    end
  endtask

  task automatic test_back_to_back();
    // run_op returns on the first idle cycle, so these starts are adjacent.
    run_op(2'b01, 32'h0001_0001, 32'h0001_0001, "b2b_first");
    run_op(2'b11, 32'd1000, 32'd7, "b2b_second");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "b2b_third");
  endtask

  task automatic test_mt();
    mt_write(1'b0, 1'b1, 32'h0000_1234);
    checks++;
    if (bus.lo !== 32'h0000_1234) begin
      errors++;
      $display("FAIL mtlo: got lo=%h want 00001234", bus.lo);
    end
    mt_write(1'b1, 1'b0, 32'hCAFE_F00D);
    checks++;
    if (bus.hi !== 32'hCAFE_F00D || bus.lo !== 32'h0000_1234) begin
      errors++;
      $display("FAIL mthi: got hi=%h lo=%h want cafef00d 00001234", bus.hi, bus.lo);
    end
  endtask

  task automatic test_abort();
    logic [31:0] hi0, lo0;
    hi0 = 32'hCAFE_F00D;
    lo0 = 32'h0000_1234;
    bus.startE = 1'b1;
    bus.mdopE  = 2'b01;
    bus.srcaE  = 32'h1111_1111;
    bus.srcbE  = 32'h2222_2222;
    @(posedge clk);        // cycle 0: accept
    @(negedge clk);        // cycle 1
    bus.startE = 1'b0;
    repeat (9) @(negedge clk);  // cycle 10
    checks++;
    if (bus.mdrunE !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: got mdrunE=%b want 1", bus.mdrunE);
    end
    bus.abort  = 1'b1;
    bus.startE = 1'b1;     // must be ignored alongside the flush
    @(posedge clk);
    @(negedge clk);        // cycle 11
    bus.abort  = 1'b0;
    bus.startE = 1'b0;
    checks++;
    if (bus.mdrunE !== 1'b0 || bus.hi !== hi0 || bus.lo !== lo0) begin
      errors++;
      $display("FAIL abort_cycle11: got mdrunE=%b hi=%h lo=%h want 0 %h %h", bus.mdrunE,
               bus.hi, bus.lo, hi0, lo0);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (bus.mdrunE !== 1'b0 || bus.hi !== hi0 || bus.lo !== lo0) begin
      errors++;
      $display("FAIL abort_later: got mdrunE=%b hi=%h lo=%h want 0 %h %h", bus.mdrunE,
               bus.hi, bus.lo, hi0, lo0);
    end
  endtask

  task automatic test_stall();
    int busy;
    int rises;
    logic [63:0] expv;
    exp_q.push_back(model(2'b11, 32'd1_000_003, 32'd97));
    bus.startE = 1'b1;
    bus.stallE = 1'b1;
    bus.mdopE  = 2'b11;
    bus.srcaE  = 32'd1_000_003;
    bus.srcbE  = 32'd97;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.mdrunE !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got mdrunE=%b want 0", i, bus.mdrunE);
      end
    end
    bus.stallE = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.mdrunE !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_rise: got mdrunE=%b want 1", bus.mdrunE);
    end
    // Instruction lingers in E for a few more cycles with startE still high.
    busy  = 0;
    rises = 1;
    for (int i = 0; i < 45; i++) begin
      if (i == 5) bus.startE = 1'b0;
      if (bus.mdrunE === 1'b1) busy++;
      @(negedge clk);
      if (i > 0 && bus.mdrunE === 1'b1 && busy >= 33) rises++;
    end
    checks++;
    if (busy !== 33 || rises !== 1) begin
      errors++;
      $display("FAIL stall_single_op: got busy=%0d ops=%0d want 33 1", busy, rises);
    end
    expv = exp_q.pop_front();
    checks++;
    if ({bus.hi, bus.lo} !== expv) begin
      errors++;
      $display("FAIL stall_result: got hi=%h lo=%h want hi=%h lo=%h", bus.hi, bus.lo,
               expv[63:32], expv[31:0]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors = 0;
    checks = 0;
    idle_inputs();
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mt();
    test_abort();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the execute stage. It owns the architectural HI/LO registers and performs MULT/MULTU/DIV/DIVU in a fixed number of cycles. It supplies the busy flag (`mdrun`) that the hazard logic uses to stall decode when an instruction needs HI/LO. HI/LO reads from decode are served combinationally from the registered outputs.

## Interface

Parameters:

- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:

- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `startE` input 1: a mult/div instruction is in E this cycle.
- `mdopE` input 2: operation select.
  - 00 = MULT
  - 01 = MULTU
  - 10 = DIV
  - 11 = DIVU
- `srcaE` input WIDTH: rs operand (multiplicand or dividend).
- `srcbE` input WIDTH: rt operand (multiplier or divisor).
- `stallE` input 1: E stage held; start is not accepted.
- `abort` input 1: exception flush; cancels any operation in progress.
- `hiwriteE` input 1: MTHI.
- `lowriteE` input 1: MTLO.
- `hiwdataE` input WIDTH: MTHI/MTLO write data.
- `mdrunE` output 1: operation in progress; goes to the hazard unit.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation

- **States:** IDLE, RUN, FIX.
- **Start acceptance:** a start is accepted in IDLE when `startE & ~stallE & ~abort`.
  - Operands are latched.
  - Signed ops latch absolute values plus sign flags: `negq = sa^sb` and `negr = sa`.
  - The iteration counter is loaded with `WIDTH`. Next state is RUN.
- **RUN, multiply:** shift-add, one multiplier bit per cycle, LSB first, into a 2·WIDTH partial product.
- **RUN, divide:** restoring division, one quotient bit per cycle, MSB first. Remainder is WIDTH+1 bits wide.
- **RUN exit:** the counter decrements each cycle. When it reaches 1 the next state is FIX.
- **FIX:** applies two's-complement negation where required:
  - Product: when `negq`.
  - Quotient: when `negq`.
  - Remainder: when `negr`.
  - The result is written to HI/LO and the next state is IDLE.
- **Result mapping:**
  - Multiply: HI = upper half of product, LO = lower half.
  - Divide: LO = quotient, HI = remainder.
- **Divide by zero:** detected at start, but the unit still runs the full cycle count.
  - Result: LO = all ones, HI = original (unsigned-form) `srcaE`.
  - No sign fix is applied.
- **Signed overflow:** −2^(WIDTH−1) / −1 gives LO = 0x80000000 and HI = 0. This falls out of the abs/negate scheme naturally.
- **MTHI/MTLO:** write only in IDLE. If they are asserted while busy they are ignored; the hazard unit guarantees this does not happen. If they coincide with an accepted start, the start wins.
- **abort:** in any state, forces IDLE next cycle.
  - HI/LO keep their pre-operation values.
  - The partial result is discarded.
  - A `startE` arriving in the same cycle is not accepted.
- **Reset:** forces the following state.
  - State = IDLE.
  - `mdrunE` = 0.
  - HI = LO = 0.
  - Counter and datapath registers = 0.
  - Reset overrides abort and start.

## Timing

- **Cycle 0:** start accepted.
- **`mdrunE`:** is 1 from cycle 1 through cycle WIDTH+1, i.e. 33 cycles for WIDTH = 32 (32 RUN cycles plus 1 FIX cycle).
- **Result visibility:** HI/LO take the new values at the clock edge ending FIX. They are visible, and `mdrunE` = 0, from cycle WIDTH+2 (cycle 34).
- **Back-to-back:** a new start may be accepted in the first cycle `mdrunE` = 0.
- **Stalled start:** a start held by `stallE` is accepted on the first cycle `stallE` falls. It is accepted exactly once, because `mdrunE` then blocks re-acceptance while the instruction remains in E.
- **`mdrunE` source:** driven directly from state (RUN or FIX). It is registered, with no combinational path from the inputs.
- **HI/LO:** registered; they change only on reset, MTHI/MTLO, or FIX.

## Test plan

- **Reset:** assert `reset` for 2 cycles with `startE` = 1 -> `hi` = `lo` = 0 and `mdrunE` = 0 throughout and one cycle after deassert.
- **MULT signed:** `srcaE` = 0xFFFFFFFD (−3), `srcbE` = 7 -> `mdrunE` high for exactly 33 cycles; then `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF -> `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
- **DIV signed:** −7 / 2 -> `lo` = 0xFFFFFFFD (−3), `hi` = 0xFFFFFFFF (−1).
- **DIV overflow:** 0x80000000 / 0xFFFFFFFF -> `lo` = 0x80000000, `hi` = 0.
- **DIVU by zero:** 5 / 0 -> after 33 busy cycles, `lo` = 0xFFFFFFFF, `hi` = 5.
- **Abort and stall:**
  - Start a MULTU, assert `abort` at cycle 10 -> `mdrunE` = 0 from cycle 11, and HI/LO unchanged.
  - Hold `startE` with `stallE` = 1 for 3 cycles, then drop `stallE` -> exactly one operation, with `mdrunE` rising one cycle after `stallE` falls.
  - MTLO with data 0x1234 in IDLE -> `lo` = 0x1234 the next cycle.
